// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the dual-port data-memory arbiter.
package dmem_arb_pkg;

    localparam int unsigned DATA_W_DEF     = 32;
    localparam int unsigned DEPTH_LOG2_DEF = 6;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/dmem_rsp_slot.sv
// One-entry response register per port: loads on grant, drains on rsp_ready.
module dmem_rsp_slot
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              load_err,
    input  logic [DATA_W-1:0] load_rdata,
    input  logic              rsp_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    slot_state_t state;

    // A load in the same cycle as a drain wins, giving back-to-back responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SLOT_EMPTY;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (load) begin
            state     <= SLOT_FULL;
            rsp_valid <= 1'b1;
            rsp_rdata <= load_rdata;
            rsp_err   <= load_err;
        end else if (state == SLOT_FULL && rsp_ready) begin
            state     <= SLOT_EMPTY;
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for a single-port word-addressed data memory.
// Define DMEM_ARB_RR_EN for round-robin contention; default is fixed port-0 priority.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [31:0]       req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp0_err,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [31:0]       req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              rsp1_err,

    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic              elig0, elig1;
    logic              gnt0, gnt1, pick1;
    logic              err0, err1;
    logic              sel_we, sel_err;
    logic [31:0]       sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [DATA_W-1:0] load_rdata;

    assign err0 = (req0_addr[1:0] != 2'b00) || (req0_addr[31:DEPTH_LOG2+2] != '0);
    assign err1 = (req1_addr[1:0] != 2'b00) || (req1_addr[31:DEPTH_LOG2+2] != '0);

    // A full slot can accept a new request when it is being drained this cycle.
    assign elig0 = !rst && req0_valid && (!rsp0_valid || rsp0_ready);
    assign elig1 = !rst && req1_valid && (!rsp1_valid || rsp1_ready);

`ifdef DMEM_ARB_RR_EN
    logic last_grant;

    assign pick1 = elig1 && (!elig0 || last_grant == PORT0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= PORT1;
        end else if (gnt0) begin
            last_grant <= PORT0;
        end else if (gnt1) begin
            last_grant <= PORT1;
        end
    end
`else
    assign pick1 = elig1 && !elig0;
`endif

    assign gnt1       = pick1;
    assign gnt0       = elig0 && !pick1;
    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    always_comb begin
        sel_we    = req0_we;
        sel_err   = err0;
        sel_addr  = req0_addr;
        sel_wdata = req0_wdata;
        if (gnt1) begin
            sel_we    = req1_we;
            sel_err   = err1;
            sel_addr  = req1_addr;
            sel_wdata = req1_wdata;
        end
    end

    assign mem_addr   = {{(32-DEPTH_LOG2){1'b0}}, sel_addr[DEPTH_LOG2+1:2]};
    assign mem_wdata  = sel_wdata;
    assign mem_we     = (gnt0 || gnt1) && sel_we && !sel_err;
    assign load_rdata = (sel_we || sel_err) ? '0 : mem_rdata;

    dmem_rsp_slot #(.DATA_W(DATA_W)) u_slot0 (
        .clk        (clk),
        .rst        (rst),
        .load       (gnt0),
        .load_err   (sel_err),
        .load_rdata (load_rdata),
        .rsp_ready  (rsp0_ready),
        .rsp_valid  (rsp0_valid),
        .rsp_rdata  (rsp0_rdata),
        .rsp_err    (rsp0_err)
    );

    dmem_rsp_slot #(.DATA_W(DATA_W)) u_slot1 (
        .clk        (clk),
        .rst        (rst),
        .load       (gnt1),
        .load_err   (sel_err),
        .load_rdata (load_rdata),
        .rsp_ready  (rsp1_ready),
        .rsp_valid  (rsp1_valid),
        .rsp_rdata  (rsp1_rdata),
        .rsp_err    (rsp1_err)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural 64-word memory.
module tb_dmem_arbiter;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned DEPTH_LOG2 = 6;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req0_valid, req0_ready, req0_we;
    logic [31:0]       req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              rsp0_valid, rsp0_ready, rsp0_err;
    logic [DATA_W-1:0] rsp0_rdata;
    logic              req1_valid, req1_ready, req1_we;
    logic [31:0]       req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              rsp1_valid, rsp1_ready, rsp1_err;
    logic [DATA_W-1:0] rsp1_rdata;
    logic              mem_we;
    logic [31:0]       mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic [31:0] tb_mem  [64] = '{default: '0};
    logic [31:0] ref_mem [64] = '{default: '0};

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    rsp_t q0[$];
    rsp_t q1[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic pend0 = 1'b0;
    logic pend1 = 1'b0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_we    (req0_we),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_rdata (rsp0_rdata),
        .rsp0_err   (rsp0_err),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_we    (req1_we),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_rdata (rsp1_rdata),
        .rsp1_err   (rsp1_err),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always @(posedge clk) if (mem_we) tb_mem[mem_addr[5:0]] <= mem_wdata;
    assign mem_rdata = tb_mem[mem_addr[5:0]];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: evaluates an accepted request and queues its expected response.
    task automatic accept(input int port, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata);
        rsp_t r;
        logic bad;
        bad     = (addr[1:0] != 2'b00) || (addr[31:8] != 24'h0);
        r.err   = bad;
        r.rdata = '0;
        check_eq("mem_addr_hi", {38'd0, mem_addr[31:6]}, 64'd0);
        if (bad) begin
            check_eq("err_no_we", mem_we, 1'b0);
        end else begin
            check_eq("mem_addr", mem_addr, addr >> 2);
            if (we) begin
                check_eq("mem_we", mem_we, 1'b1);
                check_eq("mem_wdata", mem_wdata, wdata);
                ref_mem[addr[7:2]] = wdata;
            end else begin
                check_eq("rd_no_we", mem_we, 1'b0);
                r.rdata = ref_mem[addr[7:2]];
            end
        end
        if (port == 0) q0.push_back(r);
        else           q1.push_back(r);
    endtask

    task automatic drain(input int port);
        rsp_t e;
        if (port == 0) begin
            check_eq("rsp0_expected", q0.size() != 0, 1'b1);
            if (q0.size() != 0) begin
                e = q0.pop_front();
                check_eq("rsp0_rdata", rsp0_rdata, e.rdata);
                check_eq("rsp0_err", rsp0_err, e.err);
            end
        end else begin
            check_eq("rsp1_expected", q1.size() != 0, 1'b1);
            if (q1.size() != 0) begin
                e = q1.pop_front();
                check_eq("rsp1_rdata", rsp1_rdata, e.rdata);
                check_eq("rsp1_err", rsp1_err, e.err);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            pend0 = 1'b0;
            pend1 = 1'b0;
        end else begin
            if (pend0) check_eq("lat0", rsp0_valid, 1'b1);
            if (pend1) check_eq("lat1", rsp1_valid, 1'b1);
            if (rsp0_valid && rsp0_ready) drain(0);
            if (rsp1_valid && rsp1_ready) drain(1);
            check_eq("one_grant", req0_ready && req1_ready, 1'b0);
            if (req0_valid && req0_ready) accept(0, req0_we, req0_addr, req0_wdata);
            if (req1_valid && req1_ready) accept(1, req1_we, req1_addr, req1_wdata);
            pend0 = req0_valid && req0_ready;
            pend1 = req1_valid && req1_ready;
        end
    end

    task automatic drive(input int port, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata);
        if (port == 0) begin
            req0_valid = 1'b1; req0_we = we; req0_addr = addr; req0_wdata = wdata;
        end else begin
            req1_valid = 1'b1; req1_we = we; req1_addr = addr; req1_wdata = wdata;
        end
    endtask

    task automatic wait_acc(input int port);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = (port == 0) ? req0_ready : req1_ready;
        end
        check_eq("acc_timeout", ok, 1'b1);
        @(posedge clk); #1;
        if (port == 0) req0_valid = 1'b0;
        else           req1_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [3:0]  pat;
        logic        g1;
        int          nbad;

        req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
`ifdef DMEM_ARB_RR_EN
        pat = 4'b1010;
`else
        pat = 4'b0000;
`endif

        // Reset state with requests already presented
        drive(0, 1'b1, 32'h10, 32'h1234_5678);
        drive(1, 1'b1, 32'h20, 32'h8765_4321);
        @(posedge clk); #1;
        check_eq("rst_rsp0_valid", rsp0_valid, 1'b0);
        check_eq("rst_rsp1_valid", rsp1_valid, 1'b0);
        check_eq("rst_rsp0_rdata", rsp0_rdata, 32'h0);
        check_eq("rst_rsp0_err", rsp0_err, 1'b0);
        check_eq("rst_req0_ready", req0_ready, 1'b0);
        check_eq("rst_req1_ready", req1_ready, 1'b0);
        check_eq("rst_mem_we", mem_we, 1'b0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk); #1 rst = 1'b0;
        idle(1);

        // Port 0 write then read back
        drive(0, 1'b1, 32'h10, 32'hDEAD_BEEF);
        #1;
        check_eq("wr_mem_addr", mem_addr, 32'd4);
        check_eq("wr_mem_we", mem_we, 1'b1);
        wait_acc(0);
        drive(0, 1'b0, 32'h10, 32'h0);
        #1;
        check_eq("rd_mem_addr", mem_addr, 32'd4);
        check_eq("rd_mem_we", mem_we, 1'b0);
        wait_acc(0);
        check_eq("rd_valid", rsp0_valid, 1'b1);
        check_eq("rd_data", rsp0_rdata, 32'hDEAD_BEEF);
        check_eq("rd_err", rsp0_err, 1'b0);

        // Fill words 16..31 from port 1
        for (int w = 16; w < 32; w++) begin
            drive(1, 1'b1, 32'(w * 4), 32'hA5A5_0000 | 32'(w));
            wait_acc(1);
        end

        // Reset between tests so the arbitration history starts fresh
        idle(2);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);

        // Single contention: port 0 first, port 1 next cycle
        drive(0, 1'b0, 32'h40, 32'h0);
        drive(1, 1'b0, 32'h44, 32'h0);
        @(negedge clk);
        check_eq("c1_gnt0", req0_ready, 1'b1);
        check_eq("c1_gnt1", req1_ready, 1'b0);
        @(posedge clk); #1 req0_valid = 1'b0;
        @(negedge clk);
        check_eq("c2_gnt1", req1_ready, 1'b1);
        @(posedge clk); #1 req1_valid = 1'b0;

        // Four back-to-back contentions
        drive(0, 1'b0, 32'h50, 32'h0);
        drive(1, 1'b0, 32'h40, 32'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            g1 = req1_ready;
            check_eq("rr_gnt1", req1_ready, pat[k]);
            check_eq("rr_gnt0", req0_ready, !pat[k]);
            @(posedge clk); #1;
            if (g1) req1_addr = req1_addr + 32'd4;
            else    req0_addr = req0_addr + 32'd4;
        end
        req0_valid = 1'b0;
        wait_acc(1);

        // Error accesses on port 1
        drive(1, 1'b0, 32'h102, 32'h0);
        #1 check_eq("mis_we", mem_we, 1'b0);
        wait_acc(1);
        drive(1, 1'b0, 32'h100, 32'h0);
        wait_acc(1);
        check_eq("oor_err", rsp1_err, 1'b1);
        check_eq("oor_rdata", rsp1_rdata, 32'h0);
        drive(1, 1'b1, 32'h104, 32'hFFFF_FFFF);
        #1 check_eq("oor_wr_we", mem_we, 1'b0);
        wait_acc(1);
        drive(1, 1'b1, 32'h3, 32'h1234);
        #1 check_eq("mis_wr_we", mem_we, 1'b0);
        wait_acc(1);
        check_eq("mis_wr_err", rsp1_err, 1'b1);

        // Response backpressure on port 0
        rsp0_ready = 1'b0;
        drive(0, 1'b0, 32'h10, 32'h0);
        wait_acc(0);
        drive(0, 1'b0, 32'h48, 32'h0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_eq("bp_valid", rsp0_valid, 1'b1);
            check_eq("bp_rdata", rsp0_rdata, 32'hDEAD_BEEF);
            check_eq("bp_ready", req0_ready, 1'b0);
        end
        @(posedge clk); #1;
        rsp0_ready = 1'b1;
        #1 check_eq("bp_refill", req0_ready, 1'b1);
        wait_acc(0);

        // Read-after-write across ports
        drive(0, 1'b1, 32'hC, 32'h55);
        @(negedge clk);
        check_eq("raw_wr_gnt", req0_ready, 1'b1);
        @(posedge clk); #1 req0_valid = 1'b0;
        drive(1, 1'b0, 32'hC, 32'h0);
        @(negedge clk);
        check_eq("raw_rd_gnt", req1_ready, 1'b1);
        @(posedge clk); #1 req1_valid = 1'b0;
        check_eq("raw_rdata", rsp1_rdata, 32'h55);

        // Asynchronous reset while a response is pending
        idle(1);
        rsp0_ready = 1'b0;
        drive(0, 1'b0, 32'h44, 32'h0);
        wait_acc(0);
        drive(0, 1'b1, 32'h14, 32'h1111);
        drive(1, 1'b1, 32'h24, 32'h0BAD);
        #1;
        check_eq("pre_rst_valid", rsp0_valid, 1'b1);
        check_eq("pre_rst_gnt1", req1_ready, 1'b1);
        #1 rst = 1'b1;
        #1;
        check_eq("arst_rsp0_valid", rsp0_valid, 1'b0);
        check_eq("arst_rsp0_rdata", rsp0_rdata, 32'h0);
        check_eq("arst_rsp0_err", rsp0_err, 1'b0);
        check_eq("arst_rsp1_valid", rsp1_valid, 1'b0);
        check_eq("arst_req0_ready", req0_ready, 1'b0);
        check_eq("arst_req1_ready", req1_ready, 1'b0);
        check_eq("arst_mem_we", mem_we, 1'b0);
        q0.delete();
        q1.delete();
        req0_valid = 1'b0; req1_valid = 1'b0;
        idle(2);
        check_eq("arst_word9", tb_mem[9], ref_mem[9]);
        check_eq("arst_word5", tb_mem[5], ref_mem[5]);
        rst = 1'b0;
        rsp0_ready = 1'b1;
        idle(1);

        // Post-reset sanity read
        drive(0, 1'b0, 32'h10, 32'h0);
        wait_acc(0);
        idle(3);

        check_eq("q0_empty", q0.size(), 64'd0);
        check_eq("q1_empty", q1.size(), 64'd0);
        nbad = 0;
        for (int i = 0; i < 64; i++) if (tb_mem[i] !== ref_mem[i]) nbad++;
        check_eq("mem_scan", nbad, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
